// File: rtl/dmem_write_buffer_if.sv
// Block-transfer port shared by the CPU side and the Dmem side of the write buffer.
// The master issues ren/wen with an address and data; the slave answers with ready/done pulses.
interface dmem_write_buffer_if #(
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_BITS  = 10
);
  logic                  ren;
  logic                  wen;
  logic [ADDR_BITS-1:0]  block_address;
  logic [BLOCK_BITS-1:0] din;
  logic                  ready;
  logic                  done;
  logic [BLOCK_BITS-1:0] dout;

  modport master (
    output ren, wen, block_address, din,
    input  ready, done, dout
  );

  modport slave (
    input  ren, wen, block_address, din,
    output ready, done, dout
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and Dmem: single-cycle write acceptance,
// background drain, read hits served from buffered data and misses forwarded to Dmem.
module dmem_write_buffer #(
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_BITS  = 10,
  parameter int DEPTH      = 4
) (
  input  logic                clock,
  input  logic                reset,
  dmem_write_buffer_if.slave  cpu,
  dmem_write_buffer_if.master mem,
  output logic                empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  valid_r [DEPTH];
  logic [ADDR_BITS-1:0]  addr_r  [DEPTH];
  logic [BLOCK_BITS-1:0] data_r  [DEPTH];
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  rd_pend_r;
  logic                  rd_pend_nxt_s;
  logic [ADDR_BITS-1:0]  rd_addr_r;
  logic                  ready_r;
  logic                  done_r;
  logic [BLOCK_BITS-1:0] dout_r;
  logic                  mem_ren_r;
  logic                  mem_wen_r;
  logic [ADDR_BITS-1:0]  mem_addr_r;
  logic [BLOCK_BITS-1:0] mem_din_r;
  logic                  empty_r;

  logic                  launch_wr_s;
  logic                  launch_rd_s;
  logic                  head_busy_s;
  logic                  hit_s;
  logic [PW-1:0]         hit_idx_s;
  logic                  coal_s;
  logic [PW-1:0]         coal_idx_s;
  logic                  req_ok_s;
  logic                  wr_req_s;
  logic                  rd_req_s;
  logic                  pop_s;
  logic                  rd_done_s;
  logic                  full_s;
  logic                  wr_coal_s;
  logic                  wr_push_s;
  logic                  rd_hit_s;
  logic                  rd_miss_s;

  // Request qualification: a new CPU request is only looked at outside response pulses
  // and while no read miss is still outstanding.
  always_comb begin
    req_ok_s  = !ready_r && !done_r && !rd_pend_r;
    wr_req_s  = req_ok_s && cpu.wen;
    rd_req_s  = req_ok_s && cpu.ren && !cpu.wen;
    pop_s     = (state_r == ST_WRITE) && mem.done;
    rd_done_s = (state_r == ST_READ) && mem.ready;
    full_s    = (count_r == CW'(DEPTH));
    wr_coal_s = wr_req_s && coal_s;
    wr_push_s = wr_req_s && !coal_s && (!full_s || pop_s);
    rd_hit_s  = rd_req_s && hit_s;
    rd_miss_s = rd_req_s && !hit_s;
  end

  // Address lookup, scanning oldest to youngest so the last match is the youngest entry.
  // The head is treated as in flight from the cycle its drain is launched.
  always_comb begin
    logic [PW-1:0] idx_v;
    logic          match_v;
    logic          busy_v;
    idx_v       = PW'(0);
    match_v     = 1'b0;
    busy_v      = 1'b0;
    head_busy_s = (state_r == ST_WRITE) || launch_wr_s;
    hit_s       = 1'b0;
    hit_idx_s   = PW'(0);
    coal_s      = 1'b0;
    coal_idx_s  = PW'(0);
    for (int k = 0; k < DEPTH; k++) begin
      idx_v      = head_r + PW'(k);
      match_v    = valid_r[idx_v] && (addr_r[idx_v] == cpu.block_address);
      busy_v     = head_busy_s && (idx_v == head_r);
      hit_idx_s  = match_v ? idx_v : hit_idx_s;
      hit_s      = hit_s | match_v;
      coal_idx_s = (match_v && !busy_v) ? idx_v : coal_idx_s;
      coal_s     = coal_s | (match_v && !busy_v);
    end
  end

  // Downstream FSM next state; a pending read miss outranks further drains.
  always_comb begin
    state_nxt_s = state_r;
    launch_wr_s = 1'b0;
    launch_rd_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_pend_r) begin
          state_nxt_s = ST_READ;
          launch_rd_s = 1'b1;
        end else if (count_r != CW'(0)) begin
          state_nxt_s = ST_WRITE;
          launch_wr_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem.done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem.ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Occupancy and read-pending next values.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (rd_miss_s) begin
      rd_pend_nxt_s = 1'b1;
    end else if (rd_done_s) begin
      rd_pend_nxt_s = 1'b0;
    end else begin
      rd_pend_nxt_s = rd_pend_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry storage; on a full-buffer pop-and-push the new entry lands in the freed head slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        addr_r[i]  <= {ADDR_BITS{1'b0}};
        data_r[i]  <= {BLOCK_BITS{1'b0}};
      end
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      if (wr_push_s) begin
        valid_r[tail_r] <= 1'b1;
        addr_r[tail_r]  <= cpu.block_address;
        data_r[tail_r]  <= cpu.din;
        tail_r          <= tail_r + PW'(1);
      end
      if (wr_coal_s) begin
        data_r[coal_idx_s] <= cpu.din;
      end
      count_r <= count_nxt_s;
    end
  end

  // Read-miss tracking and the registered empty flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend_r <= 1'b0;
      rd_addr_r <= {ADDR_BITS{1'b0}};
      empty_r   <= 1'b1;
    end else begin
      rd_pend_r <= rd_pend_nxt_s;
      if (rd_miss_s) begin
        rd_addr_r <= cpu.block_address;
      end
      empty_r <= (count_nxt_s == CW'(0)) && (state_nxt_s == ST_IDLE) && !rd_pend_nxt_s;
    end
  end

  // CPU response pulses and read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      dout_r  <= {BLOCK_BITS{1'b0}};
    end else begin
      ready_r <= rd_hit_s || rd_done_s;
      done_r  <= wr_coal_s || wr_push_s;
      if (rd_done_s) begin
        dout_r <= mem.dout;
      end else if (rd_hit_s) begin
        dout_r <= data_r[hit_idx_s];
      end
    end
  end

  // Dmem request outputs, held from launch until the matching completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ren_r  <= 1'b0;
      mem_wen_r  <= 1'b0;
      mem_addr_r <= {ADDR_BITS{1'b0}};
      mem_din_r  <= {BLOCK_BITS{1'b0}};
    end else begin
      if (launch_wr_s) begin
        mem_wen_r  <= 1'b1;
        mem_addr_r <= addr_r[head_r];
        mem_din_r  <= data_r[head_r];
      end else if (launch_rd_s) begin
        mem_ren_r  <= 1'b1;
        mem_addr_r <= rd_addr_r;
      end else if (pop_s) begin
        mem_wen_r <= 1'b0;
      end else if (rd_done_s) begin
        mem_ren_r <= 1'b0;
      end
    end
  end

  assign cpu.ready         = ready_r;
  assign cpu.done          = done_r;
  assign cpu.dout          = dout_r;
  assign mem.ren           = mem_ren_r;
  assign mem.wen           = mem_wen_r;
  assign mem.block_address = mem_addr_r;
  assign mem.din           = mem_din_r;
  assign empty             = empty_r;
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: the bench plays both the CPU and Dmem, and
// every expected value below is hand-derived from the intended buffer behaviour.
module tb_dmem_write_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic empty;

  dmem_write_buffer_if #(.BLOCK_BITS(128), .ADDR_BITS(10)) cpu_if ();
  dmem_write_buffer_if #(.BLOCK_BITS(128), .ADDR_BITS(10)) mem_if ();

  dmem_write_buffer #(.BLOCK_BITS(128), .ADDR_BITS(10), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .cpu   (cpu_if),
    .mem   (mem_if),
    .empty (empty)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ren_cycles = 0;
  logic [9:0]   log_addr [$];
  logic [127:0] log_data [$];

  // Dmem-side observer: every completed write and every cycle with a read request.
  always @(posedge clock) begin
    if (mem_if.ren) ren_cycles <= ren_cycles + 1;
    if (mem_if.wen && mem_if.done) begin
      log_addr.push_back(mem_if.block_address);
      log_data.push_back(mem_if.din);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [127:0] d, output int lat);
    cpu_if.wen = 1'b1;
    cpu_if.block_address = a;
    cpu_if.din = d;
    lat = -1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (cpu_if.done) begin
        lat = c;
        break;
      end
    end
    cpu_if.wen = 1'b0;
    tick();
  endtask

  task automatic cpu_read(input logic [9:0] a, output int lat, output logic [127:0] d);
    cpu_if.ren = 1'b1;
    cpu_if.block_address = a;
    lat = -1;
    d = 128'h0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (cpu_if.ready) begin
        lat = c;
        d = cpu_if.dout;
        break;
      end
    end
    cpu_if.ren = 1'b0;
    tick();
  endtask

  task automatic ack_write();
    for (int c = 0; c < 8 && !mem_if.wen; c++) tick();
    mem_if.done = 1'b1;
    tick();
    mem_if.done = 1'b0;
  endtask

  task automatic pop_log(output logic [9:0] a, output logic [127:0] d, output bit got);
    got = (log_addr.size() > 0);
    a = 10'h0;
    d = 128'h0;
    if (got) begin
      a = log_addr.pop_front();
      d = log_data.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({cpu_if.ready, cpu_if.done, mem_if.ren, mem_if.wen} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {cpu_if.ready, cpu_if.done, mem_if.ren, mem_if.wen});
    else pass_cnt++;
    total_cnt++;
    if (cpu_if.dout !== 128'h0 || mem_if.din !== 128'h0 || mem_if.block_address !== 10'h0)
      $display("FAIL reset_data: got dout %h din %h addr %h expected zeros", cpu_if.dout, mem_if.din, mem_if.block_address);
    else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty);
    else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read_hit();
    int lat;
    int ren0;
    logic [127:0] d;
    logic [9:0] la;
    logic [127:0] ld;
    bit got;
    cpu_write(10'h005, {16{8'hA5}}, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL wr_latency: got %0d expected 1", lat);
    else pass_cnt++;
    ren0 = ren_cycles;
    cpu_read(10'h005, lat, d);
    total_cnt++;
    if (lat !== 1 || d !== {16{8'hA5}})
      $display("FAIL rd_hit: got lat %0d dout %h expected lat 1 dout %h", lat, d, {16{8'hA5}});
    else pass_cnt++;
    total_cnt++;
    if (ren_cycles !== ren0) $display("FAIL rd_hit_no_memren: got %0d ren cycles expected 0", ren_cycles - ren0);
    else pass_cnt++;
    ack_write();
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h005 || ld !== {16{8'hA5}})
      $display("FAIL drain_005: got %b addr %h data %h expected addr 005 data %h", got, la, ld, {16{8'hA5}});
    else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL empty_after_drain: got %b expected 1", empty);
    else pass_cnt++;
  endtask

  task automatic test_coalesce();
    int lat;
    int lat3;
    logic [9:0] la;
    logic [127:0] ld;
    bit got;
    cpu_write(10'h00F, 128'hF, lat);
    cpu_write(10'h010, 128'h1, lat);
    cpu_write(10'h011, 128'h2, lat);
    cpu_write(10'h010, 128'h3, lat3);
    total_cnt++;
    if (lat3 !== 1) $display("FAIL coalesce_done: got %0d expected 1", lat3);
    else pass_cnt++;
    ack_write();
    ack_write();
    ack_write();
    tick();
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h00F || ld !== 128'hF)
      $display("FAIL coalesce_first: got %b addr %h data %h expected addr 00f data f", got, la, ld);
    else pass_cnt++;
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h010 || ld !== 128'h3)
      $display("FAIL coalesce_merged: got %b addr %h data %h expected addr 010 data 3", got, la, ld);
    else pass_cnt++;
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h011 || ld !== 128'h2 || log_addr.size() != 0)
      $display("FAIL coalesce_count: got %b addr %h data %h extra %0d expected addr 011 data 2 extra 0", got, la, ld, log_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_full_stall();
    int lat;
    int early;
    logic [9:0] la;
    logic [127:0] ld;
    bit got;
    for (int i = 0; i < 4; i++) cpu_write(10'h030 + 10'(i), 128'h100 + 128'(i), lat);
    cpu_if.wen = 1'b1;
    cpu_if.block_address = 10'h034;
    cpu_if.din = 128'h104;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cpu_if.done) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL full_stall: got %0d done pulses expected 0", early);
    else pass_cnt++;
    mem_if.done = 1'b1;
    tick();
    mem_if.done = 1'b0;
    total_cnt++;
    if (cpu_if.done !== 1'b1) $display("FAIL full_accept_on_pop: got done %b expected 1", cpu_if.done);
    else pass_cnt++;
    cpu_if.wen = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) ack_write();
    total_cnt++;
    if (empty !== 1'b1 || log_addr.size() != 5)
      $display("FAIL full_drain_count: got empty %b writes %0d expected empty 1 writes 5", empty, log_addr.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      pop_log(la, ld, got);
      total_cnt++;
      if (!got || la !== 10'h030 + 10'(i) || ld !== 128'h100 + 128'(i))
        $display("FAIL full_order: got addr %h data %h expected addr %h data %h", la, ld, 10'h030 + 10'(i), 128'h100 + 128'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_read_miss_during_drain();
    int lat;
    int early;
    int wait_c;
    logic [9:0] la;
    logic [127:0] ld;
    bit got;
    cpu_write(10'h040, 128'h40, lat);
    cpu_write(10'h041, 128'h41, lat);
    cpu_if.ren = 1'b1;
    cpu_if.block_address = 10'h2AA;
    early = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_if.ren || cpu_if.ready) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL miss_waits_for_write: got %0d early cycles expected 0", early);
    else pass_cnt++;
    mem_if.done = 1'b1;
    tick();
    mem_if.done = 1'b0;
    wait_c = -1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem_if.ren) begin
        wait_c = c;
        break;
      end
    end
    total_cnt++;
    if (wait_c !== 1 || mem_if.wen !== 1'b0 || mem_if.block_address !== 10'h2AA)
      $display("FAIL miss_issue: got wait %0d wen %b addr %h expected wait 1 wen 0 addr 2aa", wait_c, mem_if.wen, mem_if.block_address);
    else pass_cnt++;
    mem_if.dout = {4{32'hDEADBEEF}};
    mem_if.ready = 1'b1;
    tick();
    mem_if.ready = 1'b0;
    mem_if.dout = 128'h0;
    total_cnt++;
    if (cpu_if.ready !== 1'b1 || cpu_if.dout !== {4{32'hDEADBEEF}})
      $display("FAIL miss_data: got ready %b dout %h expected ready 1 dout %h", cpu_if.ready, cpu_if.dout, {4{32'hDEADBEEF}});
    else pass_cnt++;
    cpu_if.ren = 1'b0;
    tick();
    ack_write();
    pop_log(la, ld, got);
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h041 || ld !== 128'h41 || empty !== 1'b1)
      $display("FAIL miss_then_drain: got addr %h data %h empty %b expected addr 041 data 41 empty 1", la, ld, empty);
    else pass_cnt++;
  endtask

  task automatic test_inflight_head();
    int lat;
    logic [127:0] d;
    logic [9:0] la;
    logic [127:0] ld;
    bit got;
    cpu_write(10'h020, 128'h5, lat);
    cpu_write(10'h020, 128'h7, lat);
    cpu_read(10'h020, lat, d);
    total_cnt++;
    if (lat !== 1 || d !== 128'h7) $display("FAIL head_read_youngest: got lat %0d dout %h expected lat 1 dout 7", lat, d);
    else pass_cnt++;
    ack_write();
    ack_write();
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h020 || ld !== 128'h5)
      $display("FAIL head_unchanged: got addr %h data %h expected addr 020 data 5", la, ld);
    else pass_cnt++;
    pop_log(la, ld, got);
    total_cnt++;
    if (!got || la !== 10'h020 || ld !== 128'h7)
      $display("FAIL head_appended: got addr %h data %h expected addr 020 data 7", la, ld);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    int lat;
    int wen_seen;
    cpu_write(10'h050, 128'h50, lat);
    cpu_write(10'h051, 128'h51, lat);
    total_cnt++;
    if (mem_if.wen !== 1'b1 || empty !== 1'b0)
      $display("FAIL pre_reset_drain: got wen %b empty %b expected wen 1 empty 0", mem_if.wen, empty);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({cpu_if.ready, cpu_if.done, mem_if.ren, mem_if.wen, empty} !== 5'b00001 || mem_if.din !== 128'h0 || mem_if.block_address !== 10'h0)
      $display("FAIL reset_mid_drain: got ctrl %b din %h addr %h expected ctrl 00001 zeros", {cpu_if.ready, cpu_if.done, mem_if.ren, mem_if.wen, empty}, mem_if.din, mem_if.block_address);
    else pass_cnt++;
    tick();
    tick();
    reset = 1'b1;
    wen_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mem_if.wen) wen_seen++;
    end
    total_cnt++;
    if (wen_seen !== 0 || empty !== 1'b1)
      $display("FAIL no_write_after_reset: got %0d wen cycles empty %b expected 0 and 1", wen_seen, empty);
    else pass_cnt++;
  endtask

  initial begin
    cpu_if.ren = 1'b0;
    cpu_if.wen = 1'b0;
    cpu_if.block_address = 10'h0;
    cpu_if.din = 128'h0;
    mem_if.ready = 1'b0;
    mem_if.done = 1'b0;
    mem_if.dout = 128'h0;
    #1;
    test_reset();
    test_write_read_hit();
    test_coalesce();
    test_full_stall();
    test_read_miss_during_drain();
    test_inflight_head();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted-write buffer placed between the CPU data-side block port and Dmem, on the dmem_* nets.
- Accepts block writes from the CPU in one cycle and drains them to Dmem in the background.
- Serves CPU reads from buffered data on an address hit; otherwise forwards the read to Dmem.
- Hides Dmem write latency from the pipeline.

Parameters:
- BLOCK_BITS, 128, width of one data block.
- ADDR_BITS, 10, width of the block address.
- DEPTH, 4, number of buffer entries (power of two, at least 2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- ren  in  1  CPU read request, held until ready
- wen  in  1  CPU write request, held until done
- block_address  in  ADDR_BITS  CPU block address
- din  in  BLOCK_BITS  CPU write data
- ready  out  1  one-cycle pulse: dout valid
- done  out  1  one-cycle pulse: write accepted
- dout  out  BLOCK_BITS  read data
- mem_ren  out  1  Dmem read request
- mem_wen  out  1  Dmem write request
- mem_block_address  out  ADDR_BITS  Dmem address
- mem_din  out  BLOCK_BITS  Dmem write data
- mem_ready  in  1  Dmem read-data-valid pulse
- mem_done  in  1  Dmem write-complete pulse
- mem_dout  in  BLOCK_BITS  Dmem read data
- empty  out  1  no valid entries and no Dmem op in flight

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries invalid; count=0; FSM in IDLE.
  - ready, done, mem_ren, mem_wen = 0; dout, mem_block_address, mem_din = 0; empty = 1.
  - Any in-flight Dmem op is abandoned; pending CPU request is dropped.
- Storage:
  - circular FIFO of DEPTH entries, each {valid, addr, data}; head/tail pointers wrap modulo DEPTH.
  - count is 0..DEPTH.
- CPU side:
  - One outstanding request at a time.
  - The block ignores ren/wen in any cycle where ready or done is high; the requester drops its request the cycle after the pulse.
  - ren and wen both high: wen wins, ren ignored.
- CPU write:
  - If a valid non-in-flight entry has the same address, its data is overwritten (coalesce); count unchanged.
  - Else, if count<DEPTH, write at tail, tail++, count++.
  - done pulses in the cycle after acceptance (1-cycle latency).
  - If count==DEPTH and there is no coalesce target, stall: done is withheld until a pop frees a slot. A pop and an accept in the same cycle are legal; count stays unchanged.
  - A write matching the in-flight head entry is appended as a new entry; the head's data is never modified while in flight.
- CPU read:
  - Hit = youngest valid entry with a matching address, including the in-flight head.
  - On a hit, dout = that entry's data and ready pulses the next cycle.
  - On a miss, a read-pending flag is set and the read goes to Dmem (see FSM). dout = mem_dout and ready pulses the cycle after mem_ready.
- Downstream FSM (states IDLE, WRITE, READ):
  - IDLE, read-pending: go to READ, drive mem_ren=1 and mem_block_address.
  - IDLE, otherwise count>0: go to WRITE, drive mem_wen=1 with the head addr/data.
  - READ: hold mem_ren until mem_ready. Then capture mem_dout, clear read-pending, return to IDLE.
  - WRITE: hold mem_wen until mem_done. Then invalidate head, head++, count--, return to IDLE.
  - A read miss arriving during WRITE waits for mem_done, then takes priority over further drains.
  - Requests drop the cycle after the Dmem pulse. Dmem pulses are ignored outside the matching state.
- empty = (count==0) && FSM==IDLE && !read-pending; registered.
- Ordering: reads never bypass a buffered write to the same address; misses only go to Dmem when no entry matches.

Test Plan:
- Reset mid-drain: 2 writes queued, FSM in WRITE, pull reset low → all outputs 0, empty=1. After release, no Dmem write occurs.
- Write then read-hit: write addr 0x005 data 0xA5A5… → done at +1. Read 0x005 before drain → ready at +1, dout=0xA5A5…, no mem_ren.
- Coalesce: write 0x010=1, 0x011=2, 0x010=3 (first not yet in flight) → count=2. The Dmem write for 0x010 carries 3.
- Full stall: hold mem_done=0, write 4 distinct addresses → count=4. 5th write: done withheld; first mem_done → 5th accepted, done pulses, count=4.
- Read miss during drain: WRITE in progress, read 0x2AA (not buffered) → mem_ren only after mem_done. The read is issued before the next drain; dout=mem_dout, ready at mem_ready+1.
- In-flight head hazard: head 0x020 in WRITE, CPU writes 0x020=7 → appended entry, head data unchanged. A read of 0x020 returns 7.
